// File: rtl/txt_score_line_pkg.sv
// Shared text constants and FSM state type for the score line text source.
package txt_score_line_pkg;

    localparam int unsigned TXT_COLS = 16;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_0     = 7'h30;
    localparam logic [6:0] ASCII_1     = 7'h31;
    localparam logic [6:0] ASCII_2     = 7'h32;
    localparam logic [6:0] ASCII_COLON = 7'h3A;
    localparam logic [6:0] ASCII_P     = 7'h50;

    typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, COMMIT} state_t;

    function automatic logic [6:0] digit_cell(input logic [3:0] nib, input logic blank,
                                              input logic [6:0] space);
        return blank ? space : (ASCII_0 + {3'b000, nib});
    endfunction

endpackage

// File: rtl/bin2bcd8_step.sv
// One double-dabble iteration: add-3 correction on each BCD nibble, then shift the
// {bcd, bin} pair left by one bit.
module bin2bcd8_step (
    input  logic [11:0] i_bcd,
    input  logic [7:0]  i_bin,
    output logic [11:0] o_bcd,
    output logic [7:0]  o_bin
);

    logic [11:0] w_adj;

    always_comb begin
        w_adj = i_bcd;
        for (int unsigned n = 0; n < 3; n++) begin
            if (i_bcd[n*4 +: 4] >= 4'd5) begin
                w_adj[n*4 +: 4] = i_bcd[n*4 +: 4] + 4'd3;
            end
        end
    end

    assign {o_bcd, o_bin} = {w_adj, i_bin} << 1;

endmodule

// File: rtl/txt_score_line.sv
// Run-time built 16-char score line "P1 LLL : RRR P2 ": sequential binary-to-BCD
// conversion of both scores, committed atomically, read through a 1-cycle char mux.
module txt_score_line
    import txt_score_line_pkg::*;
#(
    parameter bit         BLANK_LEADING = 1'b1,
    parameter logic [6:0] CHAR_SPACE    = ASCII_SPACE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score_l,
    input  logic [7:0] score_r,
    input  logic       update,
    output logic       busy,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code
);

    state_t      r_state;
    logic [3:0]  r_step;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [7:0]  r_opr_r;
    logic [11:0] r_res_l;
    logic [11:0] r_disp_l;
    logic [11:0] r_disp_r;
    logic        r_pending;
    logic        r_busy;
    logic [6:0]  r_char_code;

    logic [11:0] w_bcd;
    logic [7:0]  w_bin;

    bin2bcd8_step u_step (
        .i_bcd (r_bcd),
        .i_bin (r_bin),
        .o_bcd (w_bcd),
        .o_bin (w_bin)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_step    <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_opr_r   <= '0;
            r_res_l   <= '0;
            r_disp_l  <= '0;
            r_disp_r  <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Requests arriving in any non-IDLE state (COMMIT included) collapse into one.
            if (r_state != IDLE) begin
                r_pending <= r_pending | update;
            end
            case (r_state)
                IDLE: begin
                    if (update || r_pending) begin
                        r_bin     <= score_l;
                        r_opr_r   <= score_r;
                        r_bcd     <= '0;
                        r_step    <= '0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= CONV_L;
                    end
                end
                CONV_L: begin
                    r_step <= r_step + 4'd1;
                    if (r_step == 4'd7) begin
                        r_res_l <= w_bcd;
                        r_bcd   <= '0;
                        r_bin   <= r_opr_r;
                        r_step  <= '0;
                        r_state <= CONV_R;
                    end else begin
                        r_bcd <= w_bcd;
                        r_bin <= w_bin;
                    end
                end
                CONV_R: begin
                    r_step <= r_step + 4'd1;
                    r_bcd  <= w_bcd;
                    r_bin  <= w_bin;
                    if (r_step == 4'd7) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_disp_l <= r_res_l;
                    r_disp_r <= r_bcd;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [3:0] w_col;
    logic [3:0] w_row;
    logic [6:0] w_char;

    assign w_col = char_xy[3:0];
    assign w_row = char_xy[7:4];

    // Reads only ever see the display registers, so a half-finished conversion never shows.
    always_comb begin
        w_char = CHAR_SPACE;
        if (w_row == 4'd0) begin
            case (w_col)
                4'd0:    w_char = ASCII_P;
                4'd1:    w_char = ASCII_1;
                4'd3:    w_char = digit_cell(r_disp_l[11:8],
                                             BLANK_LEADING && (r_disp_l[11:8] == 4'd0), CHAR_SPACE);
                4'd4:    w_char = digit_cell(r_disp_l[7:4],
                                             BLANK_LEADING && (r_disp_l[11:4] == 8'd0), CHAR_SPACE);
                4'd5:    w_char = digit_cell(r_disp_l[3:0], 1'b0, CHAR_SPACE);
                4'd7:    w_char = ASCII_COLON;
                4'd9:    w_char = digit_cell(r_disp_r[11:8],
                                             BLANK_LEADING && (r_disp_r[11:8] == 4'd0), CHAR_SPACE);
                4'd10:   w_char = digit_cell(r_disp_r[7:4],
                                             BLANK_LEADING && (r_disp_r[11:4] == 8'd0), CHAR_SPACE);
                4'd11:   w_char = digit_cell(r_disp_r[3:0], 1'b0, CHAR_SPACE);
                4'd13:   w_char = ASCII_P;
                4'd14:   w_char = ASCII_2;
                default: w_char = CHAR_SPACE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_char_code <= CHAR_SPACE;
        end else begin
            r_char_code <= w_char;
        end
    end

    assign busy      = r_busy;
    assign char_code = r_char_code;

endmodule

// File: tb/tb_txt_score_line.sv
// Randomized self-checking bench for txt_score_line against a string-formatting model.
module tb_txt_score_line;
    import txt_score_line_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] score_l = '0;
    logic [7:0] score_r = '0;
    logic       update = 1'b0;
    logic       busy;
    logic [7:0] char_xy = '0;
    logic [6:0] char_code;

    int n_pass = 0;
    int n_total = 0;
    int cur_l = 0;
    int cur_r = 0;
    logic [6:0] got_line [TXT_COLS];

    txt_score_line #(.BLANK_LEADING(1'b1), .CHAR_SPACE(7'h20)) dut (
        .clk(clk), .rst(rst), .score_l(score_l), .score_r(score_r), .update(update),
        .busy(busy), .char_xy(char_xy), .char_code(char_code)
    );

    always #5 clk = ~clk;

    // Model: the line is just "P1 %3d : %3d P2 " -- width-3 decimal gives the blanking.
    function automatic logic [6:0] exp_char(input int l, input int r, input int row, input int col);
        string s;
        byte   b;
        if (row != 0) return 7'h20;
        s = $sformatf("P1 %3d : %3d P2 ", l, r);
        b = s[col];
        return b[6:0];
    endfunction

    task automatic read_line();
        for (int col = 0; col < TXT_COLS; col++) begin
            @(negedge clk);
            char_xy = {4'd0, col[3:0]};
            @(posedge clk);
            #1 got_line[col] = char_code;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy);
        else n_pass++;
        n_total++;
        if (char_code !== 7'h20) $display("FAIL reset_char got=%h exp=20", char_code);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        read_line();
        for (int col = 0; col < TXT_COLS; col++) begin
            n_total++;
            if (got_line[col] !== exp_char(0, 0, 0, col))
                $display("FAIL reset_line col=%0d got=%h exp=%h", col, got_line[col], exp_char(0, 0, 0, col));
            else n_pass++;
        end
        @(negedge clk);
        char_xy = 8'h00;
        @(posedge clk);
        @(negedge clk);
        char_xy = 8'h01;
        #1;
        n_total++;
        if (char_code !== 7'h50) $display("FAIL latency_hold got=%h exp=50", char_code);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (char_code !== 7'h31) $display("FAIL latency_one got=%h exp=31", char_code);
        else n_pass++;
    endtask

    task automatic test_convert(input int l, input int r);
        int bad_busy;
        bad_busy = 0;
        @(negedge clk);
        score_l = l[7:0];
        score_r = r[7:0];
        update = 1'b1;
        @(posedge clk);
        #1 if (busy !== 1'b1) bad_busy++;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            update = 1'b0;
            score_l = 8'($urandom);
            score_r = 8'($urandom);
            @(posedge clk);
            #1 if (busy !== (k < 17)) bad_busy++;
        end
        n_total++;
        if (bad_busy != 0) $display("FAIL convert_busy l=%0d r=%0d wrong_cycles=%0d exp=0", l, r, bad_busy);
        else n_pass++;
        cur_l = l;
        cur_r = r;
        read_line();
        for (int col = 0; col < TXT_COLS; col++) begin
            n_total++;
            if (got_line[col] !== exp_char(cur_l, cur_r, 0, col))
                $display("FAIL convert_line l=%0d r=%0d col=%0d got=%h exp=%h",
                         l, r, col, got_line[col], exp_char(cur_l, cur_r, 0, col));
            else n_pass++;
        end
    endtask

    task automatic test_no_tearing(input int l, input int r);
        int digit_cols [6] = '{3, 4, 5, 9, 10, 11};
        int col;
        logic [6:0] exp;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            col = digit_cols[$urandom_range(0, 5)];
            char_xy = {4'd0, col[3:0]};
            update = (k == 0);
            if (k == 0) begin
                score_l = l[7:0];
                score_r = r[7:0];
            end
            @(posedge clk);
            exp = (k <= 17) ? exp_char(cur_l, cur_r, 0, col) : exp_char(l, r, 0, col);
            #1;
            n_total++;
            if (char_code !== exp) $display("FAIL tearing k=%0d col=%0d got=%h exp=%h", k, col, char_code, exp);
            else n_pass++;
        end
        cur_l = l;
        cur_r = r;
    endtask

    task automatic test_back_to_back();
        int bad_busy;
        bad_busy = 0;
        @(negedge clk);
        score_l = 8'd201;
        score_r = 8'd46;
        char_xy = 8'h05;
        update = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            update = (k == 5);
            if (k == 5) begin
                score_l = 8'd9;
                score_r = 8'd9;
            end
            @(posedge clk);
            #1 if (busy !== ((k <= 16) || (k >= 18 && k <= 34))) bad_busy++;
            if (k == 18) begin
                n_total++;
                if (char_code !== exp_char(201, 46, 0, 5))
                    $display("FAIL b2b_first_commit got=%h exp=%h", char_code, exp_char(201, 46, 0, 5));
                else n_pass++;
            end
        end
        n_total++;
        if (bad_busy != 0) $display("FAIL b2b_busy wrong_cycles=%0d exp=0", bad_busy);
        else n_pass++;
        cur_l = 9;
        cur_r = 9;
        read_line();
        for (int col = 0; col < TXT_COLS; col++) begin
            n_total++;
            if (got_line[col] !== exp_char(9, 9, 0, col))
                $display("FAIL b2b_line col=%0d got=%h exp=%h", col, got_line[col], exp_char(9, 9, 0, col));
            else n_pass++;
        end
    endtask

    task automatic test_update_at_commit(input int l, input int r);
        int bad_busy;
        bad_busy = 0;
        @(negedge clk);
        score_l = 8'd33;
        score_r = 8'd44;
        update = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            update = (k == 17);
            if (k == 17) begin
                score_l = l[7:0];
                score_r = r[7:0];
            end
            @(posedge clk);
            #1 if (busy !== ((k <= 16) || (k >= 18 && k <= 34))) bad_busy++;
        end
        n_total++;
        if (bad_busy != 0) $display("FAIL commit_pending_busy wrong_cycles=%0d exp=0", bad_busy);
        else n_pass++;
        cur_l = l;
        cur_r = r;
        read_line();
        for (int col = 0; col < TXT_COLS; col++) begin
            n_total++;
            if (got_line[col] !== exp_char(l, r, 0, col))
                $display("FAIL commit_pending_line col=%0d got=%h exp=%h", col, got_line[col], exp_char(l, r, 0, col));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int bad_busy;
        int row;
        int col;
        bad_busy = 0;
        @(negedge clk);
        score_l = 8'd42;
        score_r = 8'd77;
        update = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            update = (k == 5);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL midreset_busy got=%0b exp=0", busy);
        else n_pass++;
        n_total++;
        if (char_code !== 7'h20) $display("FAIL midreset_char got=%h exp=20", char_code);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1 if (busy !== 1'b0) bad_busy++;
        end
        n_total++;
        if (bad_busy != 0) $display("FAIL midreset_no_restart wrong_cycles=%0d exp=0", bad_busy);
        else n_pass++;
        cur_l = 0;
        cur_r = 0;
        read_line();
        for (int c = 0; c < TXT_COLS; c++) begin
            n_total++;
            if (got_line[c] !== exp_char(0, 0, 0, c))
                $display("FAIL midreset_line col=%0d got=%h exp=%h", c, got_line[c], exp_char(0, 0, 0, c));
            else n_pass++;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            row = (k < 3) ? 1 : $urandom_range(1, 15);
            col = (k < 3) ? k * 7 % 16 : $urandom_range(0, 15);
            char_xy = {row[3:0], col[3:0]};
            @(posedge clk);
            #1;
            n_total++;
            if (char_code !== exp_char(0, 0, row, col))
                $display("FAIL row_blank row=%0d col=%0d got=%h exp=%h", row, col, char_code, exp_char(0, 0, row, col));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_convert(7, 123);
        test_no_tearing(255, 0);
        test_convert(100, 58);
        for (int i = 0; i < 6; i++) begin
            test_convert($urandom_range(0, 255), $urandom_range(0, 255));
        end
        test_back_to_back();
        test_update_at_commit(250, 10);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
